// File: rtl/dram_controller.sv
// dram_controller: single-requester SDR SDRAM controller for a 16-bit part.
// Runs the power-up init sequence, periodic auto-refresh, and turns single-word
// read/write requests into ACT -> READ/WRITE-with-auto-precharge sequences.
module dram_controller #(
  parameter int T_INIT           = 20000,
  parameter int T_RP             = 2,
  parameter int T_RCD            = 2,
  parameter int T_RFC            = 7,
  parameter int T_WR             = 2,
  parameter int CAS_LAT          = 2,
  parameter int REFRESH_INTERVAL = 780,
  parameter int INIT_REFRESHES   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [24:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_wmask,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        init_done,
  output logic [12:0] dram_a,
  output logic [1:0]  dram_ba,
  output logic [15:0] dram_dq_out,
  output logic        dram_dq_oe,
  input  logic [15:0] dram_dq_in,
  output logic [1:0]  dram_dqm,
  output logic        dram_cke,
  output logic        dram_ras_n,
  output logic        dram_cas_n,
  output logic        dram_we_n
);

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP   = 3'b111;
  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_READ  = 3'b101;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_PRE   = 3'b010;
  localparam logic [2:0] CMD_REF   = 3'b001;
  localparam logic [2:0] CMD_MRS   = 3'b000;

  // Burst write, CAS latency, sequential, burst length 1.
  localparam logic [12:0] MODE_WORD = {3'b000, 1'b0, 2'b00, 3'(CAS_LAT), 1'b0, 3'b000};

  // One down-counter times every wait, so size it for the longest one.
  localparam int CNT_W = $clog2(T_INIT + T_RFC + T_WR + T_RP + T_RCD + CAS_LAT + 4);
  localparam int RC_W  = $clog2(INIT_REFRESHES + 1);
  localparam int RT_W  = $clog2(REFRESH_INTERVAL + 1);

  typedef enum logic [3:0] {
    S_INIT_WAIT,
    S_INIT_PRE,
    S_INIT_REF,
    S_INIT_MRS,
    S_IDLE,
    S_REFRESH,
    S_ACTIVATE,
    S_READ,
    S_READ_WAIT,
    S_WRITE,
    S_WRITE_RECOVER
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [RC_W-1:0]   ref_cnt_reg;
  logic [RT_W-1:0]   refresh_timer_reg;
  logic              refresh_pending_reg;
  logic              refresh_expire;
  logic              we_reg;
  logic [1:0]        ba_reg;
  logic [9:0]        col_reg;
  logic [15:0]       wdata_reg;
  logic [1:0]        wmask_reg;

  assign refresh_expire = init_done && (refresh_timer_reg == RT_W'(REFRESH_INTERVAL - 1));

  // Requests are only taken in IDLE after init, and a pending refresh wins.
  assign req_ready = (state_reg == S_IDLE) && init_done && !refresh_pending_reg;

  // Free-running refresh interval timer, started once init is complete.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_timer_reg <= '0;
    end else if (init_done) begin
      if (refresh_expire) refresh_timer_reg <= '0;
      else                refresh_timer_reg <= refresh_timer_reg + RT_W'(1);
    end
  end

  // Main controller FSM; every SDRAM pin and status output is registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg           <= S_INIT_WAIT;
      cnt_reg             <= CNT_W'(T_INIT);
      ref_cnt_reg         <= '0;
      refresh_pending_reg <= 1'b0;
      we_reg              <= 1'b0;
      ba_reg              <= 2'b00;
      col_reg             <= '0;
      wdata_reg           <= '0;
      wmask_reg           <= 2'b00;
      {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_NOP;
      dram_a              <= '0;
      dram_ba             <= 2'b00;
      dram_dqm            <= 2'b11;
      dram_dq_oe          <= 1'b0;
      dram_dq_out         <= '0;
      dram_cke            <= 1'b0;
      rdata               <= '0;
      rdata_valid         <= 1'b0;
      init_done           <= 1'b0;
    end else begin
      // Defaults: NOP, bus released, masks set, no read strobe.
      {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_NOP;
      dram_cke    <= 1'b1;
      dram_dq_oe  <= 1'b0;
      dram_dqm    <= 2'b11;
      rdata_valid <= 1'b0;

      case (state_reg)
        S_INIT_WAIT: begin
          if (cnt_reg == '0) begin
            {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_PRE;
            dram_a    <= 13'h0400;  // a[10] selects all banks
            state_reg <= S_INIT_PRE;
            cnt_reg   <= CNT_W'(T_RP);
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        S_INIT_PRE: begin
          if (cnt_reg == '0) begin
            {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_REF;
            state_reg   <= S_INIT_REF;
            cnt_reg     <= CNT_W'(T_RFC);
            ref_cnt_reg <= RC_W'(INIT_REFRESHES - 1);
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        S_INIT_REF: begin
          if (cnt_reg == '0) begin
            if (ref_cnt_reg == '0) begin
              {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_MRS;
              dram_a    <= MODE_WORD;
              dram_ba   <= 2'b00;
              state_reg <= S_INIT_MRS;
              cnt_reg   <= CNT_W'(2);
            end else begin
              {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_REF;
              ref_cnt_reg <= ref_cnt_reg - RC_W'(1);
              cnt_reg     <= CNT_W'(T_RFC);
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        S_INIT_MRS: begin
          if (cnt_reg == '0) begin
            init_done <= 1'b1;
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        S_IDLE: begin
          if (refresh_pending_reg) begin
            {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_REF;
            refresh_pending_reg <= 1'b0;
            state_reg <= S_REFRESH;
            cnt_reg   <= CNT_W'(T_RFC);
          end else if (req_valid && init_done) begin
            we_reg    <= req_we;
            ba_reg    <= req_addr[24:23];
            col_reg   <= req_addr[9:0];
            wdata_reg <= req_wdata;
            wmask_reg <= req_wmask;
            {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_ACT;
            dram_ba   <= req_addr[24:23];
            dram_a    <= req_addr[22:10];
            state_reg <= S_ACTIVATE;
            cnt_reg   <= CNT_W'(T_RCD - 1);
          end
        end

        S_REFRESH: begin
          if (cnt_reg == '0) state_reg <= S_IDLE;
          else               cnt_reg   <= cnt_reg - CNT_W'(1);
        end

        S_ACTIVATE: begin
          if (cnt_reg == '0) begin
            dram_ba <= ba_reg;
            dram_a  <= {2'b00, 1'b1, col_reg};  // a[10] = auto-precharge
            if (we_reg) begin
              {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_WRITE;
              dram_dq_oe  <= 1'b1;
              dram_dq_out <= wdata_reg;
              dram_dqm    <= ~wmask_reg;
              state_reg   <= S_WRITE;
            end else begin
              {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_READ;
              dram_dqm  <= 2'b00;
              state_reg <= S_READ;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        S_WRITE: begin
          // Write recovery plus auto-precharge time before the bank is usable.
          state_reg <= S_WRITE_RECOVER;
          cnt_reg   <= CNT_W'(T_WR + T_RP - 2);
        end

        S_WRITE_RECOVER: begin
          if (cnt_reg == '0) state_reg <= S_IDLE;
          else               cnt_reg   <= cnt_reg - CNT_W'(1);
        end

        S_READ: begin
          dram_dqm  <= 2'b00;
          state_reg <= S_READ_WAIT;
          cnt_reg   <= CNT_W'(CAS_LAT);
        end

        S_READ_WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
              // Data is on the pins CAS_LAT cycles after READ.
              rdata       <= dram_dq_in;
              rdata_valid <= 1'b1;
            end else begin
              dram_dqm <= 2'b00;
            end
          end
        end

        default: state_reg <= S_INIT_WAIT;
      endcase

      // An expiry always marks a refresh as owed, even on the cycle one issues.
      if (refresh_expire) refresh_pending_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_controller.sv
// tb_dram_controller: directed bench for dram_controller with a small SDRAM model.
module tb_dram_controller;

  localparam int T_INIT           = 200;
  localparam int T_RP             = 2;
  localparam int T_RCD            = 2;
  localparam int T_RFC            = 7;
  localparam int T_WR             = 2;
  localparam int CAS_LAT          = 2;
  localparam int REFRESH_INTERVAL = 780;
  localparam int INIT_REFRESHES   = 8;

  localparam logic [2:0] C_NOP   = 3'b111;
  localparam logic [2:0] C_ACT   = 3'b011;
  localparam logic [2:0] C_READ  = 3'b101;
  localparam logic [2:0] C_WRITE = 3'b100;
  localparam logic [2:0] C_PRE   = 3'b010;
  localparam logic [2:0] C_REF   = 3'b001;
  localparam logic [2:0] C_MRS   = 3'b000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [24:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_wmask;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        init_done;
  logic [12:0] dram_a;
  logic [1:0]  dram_ba;
  logic [15:0] dram_dq_out;
  logic        dram_dq_oe;
  logic [15:0] dram_dq_in = 16'h0000;
  logic [1:0]  dram_dqm;
  logic        dram_cke;
  logic        dram_ras_n;
  logic        dram_cas_n;
  logic        dram_we_n;
  logic [2:0]  cmd;

  int checks = 0;
  int errors = 0;
  bit early_ready;

  assign cmd = {dram_ras_n, dram_cas_n, dram_we_n};

  always #5 clk = ~clk;

  dram_controller #(
    .T_INIT(T_INIT), .T_RP(T_RP), .T_RCD(T_RCD), .T_RFC(T_RFC), .T_WR(T_WR),
    .CAS_LAT(CAS_LAT), .REFRESH_INTERVAL(REFRESH_INTERVAL), .INIT_REFRESHES(INIT_REFRESHES)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rdata(rdata), .rdata_valid(rdata_valid), .init_done(init_done),
    .dram_a(dram_a), .dram_ba(dram_ba), .dram_dq_out(dram_dq_out),
    .dram_dq_oe(dram_dq_oe), .dram_dq_in(dram_dq_in), .dram_dqm(dram_dqm),
    .dram_cke(dram_cke), .dram_ras_n(dram_ras_n), .dram_cas_n(dram_cas_n),
    .dram_we_n(dram_we_n)
  );

  // SDRAM model: word memory keyed by {bank,row,col}, read data driven for
  // exactly one cycle, CAS_LAT cycles after the READ command.
  logic [15:0] mem [logic [24:0]];
  logic [12:0] open_row [4];
  int          rd_cnt = 0;
  logic [15:0] rd_word = 16'h0000;

  always @(negedge clk) begin
    logic [24:0] key;
    logic [15:0] cur;
    dram_dq_in = 16'h0000;
    if (rd_cnt != 0) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 0) dram_dq_in = rd_word;
    end
    if (reset_n && dram_cke) begin
      if (cmd == C_ACT) begin
        open_row[dram_ba] = dram_a;
      end else if (cmd == C_WRITE) begin
        key = {dram_ba, open_row[dram_ba], dram_a[9:0]};
        cur = mem.exists(key) ? mem[key] : 16'h0000;
        if (!dram_dqm[1]) cur[15:8] = dram_dq_out[15:8];
        if (!dram_dqm[0]) cur[7:0]  = dram_dq_out[7:0];
        mem[key] = cur;
      end else if (cmd == C_READ) begin
        key = {dram_ba, open_row[dram_ba], dram_a[9:0]};
        rd_word = mem.exists(key) ? mem[key] : 16'h0000;
        rd_cnt = CAS_LAT;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cmd"},         32'(cmd), 32'(C_NOP));
    chk({tag, "_a"},           32'(dram_a), 32'h0);
    chk({tag, "_ba"},          32'(dram_ba), 32'h0);
    chk({tag, "_dqm"},         32'(dram_dqm), 32'h3);
    chk({tag, "_dq_oe"},       32'(dram_dq_oe), 32'h0);
    chk({tag, "_dq_out"},      32'(dram_dq_out), 32'h0);
    chk({tag, "_cke"},         32'(dram_cke), 32'h0);
    chk({tag, "_req_ready"},   32'(req_ready), 32'h0);
    chk({tag, "_rdata"},       32'(rdata), 32'h0);
    chk({tag, "_rdata_valid"}, 32'(rdata_valid), 32'h0);
    chk({tag, "_init_done"},   32'(init_done), 32'h0);
  endtask

  // Counts NOP cycles until the next non-NOP command (bounded).
  task automatic wait_cmd(output int gap, output logic [2:0] c);
    gap = 0;
    c = C_NOP;
    for (int n = 0; n < T_INIT + 50; n++) begin
      tick();
      if (req_ready) early_ready = 1'b1;
      if (cmd != C_NOP) begin
        c = cmd;
        break;
      end
      gap++;
    end
  endtask

  // Called right after reset_n is released on a falling edge.
  task automatic check_init();
    int gap;
    int n;
    logic [2:0] c;
    early_ready = 1'b0;
    tick();
    chk("init_cke_first_cycle", 32'(dram_cke), 32'h1);
    wait_cmd(gap, c);
    chk("init_nop_count", 32'(gap + 1), 32'(T_INIT));
    chk("init_pre_cmd", 32'(c), 32'(C_PRE));
    chk("init_pre_a10", 32'(dram_a[10]), 32'h1);
    for (int i = 0; i < INIT_REFRESHES; i++) begin
      wait_cmd(gap, c);
      chk("init_ref_cmd", 32'(c), 32'(C_REF));
      chk("init_ref_gap", 32'(gap), (i == 0) ? 32'(T_RP) : 32'(T_RFC));
    end
    wait_cmd(gap, c);
    chk("init_mrs_cmd", 32'(c), 32'(C_MRS));
    chk("init_mrs_gap", 32'(gap), 32'(T_RFC));
    chk("init_mrs_a", 32'(dram_a), 32'h020);
    chk("init_mrs_ba", 32'(dram_ba), 32'h0);
    n = 0;
    while (!init_done && n < 20) begin
      if (req_ready) early_ready = 1'b1;
      tick();
      n++;
    end
    chk("init_done_delay", 32'(n), 32'd3);
    chk("init_no_early_ready", 32'(early_ready), 32'h0);
    chk("init_ready_after", 32'(req_ready), 32'h1);
  endtask

  // Waits for req_ready, presents one request for one cycle; returns at cycle 1.
  task automatic start_req(input logic we, input logic [24:0] addr,
                           input logic [15:0] wd, input logic [1:0] wm);
    int n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wmask = wm;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [24:0] addr, input logic [15:0] wd, input logic [1:0] wm,
                          input logic [1:0] e_ba, input logic [12:0] e_row,
                          input logic [12:0] e_a, input logic [1:0] e_dqm);
    int n;
    start_req(1'b1, addr, wd, wm);
    chk("wr_act_cmd", 32'(cmd), 32'(C_ACT));
    chk("wr_act_ba", 32'(dram_ba), 32'(e_ba));
    chk("wr_act_row", 32'(dram_a), 32'(e_row));
    chk("wr_busy", 32'(req_ready), 32'h0);
    tick();
    chk("wr_trcd_nop", 32'(cmd), 32'(C_NOP));
    tick();
    chk("wr_write_cmd", 32'(cmd), 32'(C_WRITE));
    chk("wr_write_a", 32'(dram_a), 32'(e_a));
    chk("wr_write_ba", 32'(dram_ba), 32'(e_ba));
    chk("wr_dq_oe", 32'(dram_dq_oe), 32'h1);
    chk("wr_dq_out", 32'(dram_dq_out), 32'(wd));
    chk("wr_dqm", 32'(dram_dqm), 32'(e_dqm));
    tick();
    chk("wr_after_oe", 32'(dram_dq_oe), 32'h0);
    chk("wr_after_dqm", 32'(dram_dqm), 32'h3);
    n = 4;
    while (!req_ready && n < 40) begin
      tick();
      n++;
    end
    chk("wr_ready_cycle", 32'(n), 32'd7);
  endtask

  task automatic do_read(input logic [24:0] addr, input logic [1:0] e_ba,
                         input logic [12:0] e_row, input logic [12:0] e_a,
                         input logic [15:0] e_data);
    start_req(1'b0, addr, 16'h0000, 2'b00);
    chk("rd_act_cmd", 32'(cmd), 32'(C_ACT));
    chk("rd_act_ba", 32'(dram_ba), 32'(e_ba));
    chk("rd_act_row", 32'(dram_a), 32'(e_row));
    tick();
    tick();
    chk("rd_read_cmd", 32'(cmd), 32'(C_READ));
    chk("rd_read_a", 32'(dram_a), 32'(e_a));
    chk("rd_read_dqm", 32'(dram_dqm), 32'h0);
    chk("rd_read_oe", 32'(dram_dq_oe), 32'h0);
    tick();
    chk("rd_valid_c4", 32'(rdata_valid), 32'h0);
    tick();
    chk("rd_valid_c5", 32'(rdata_valid), 32'h0);
    tick();
    chk("rd_valid_c6", 32'(rdata_valid), 32'h1);
    chk("rd_data_c6", 32'(rdata), 32'(e_data));
    tick();
    chk("rd_valid_c7", 32'(rdata_valid), 32'h0);
    chk("rd_ready_c7", 32'(req_ready), 32'h1);
    chk("rd_data_hold", 32'(rdata), 32'(e_data));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_ref;
    int ref_at;
    int nref;
    int nvalid;
    bit ready_bad;
    bit data_bad;

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = 2'b00;
    mem[25'h1ABCDEF] = 16'h12C3;

    // Reset state and first init sequence.
    tick();
    tick();
    tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    check_init();

    // Directed writes and reads.
    do_write(25'h1ABCDEF, 16'hA5C3, 2'b10, 2'd3, 13'h0AF3, 13'h05EF, 2'b01);
    do_read (25'h1ABCDEF, 2'd3, 13'h0AF3, 13'h05EF, 16'hA5C3);
    do_write(25'h0012345, 16'h3C5A, 2'b11, 2'd0, 13'h0048, 13'h0745, 2'b00);
    do_write(25'h0012345, 16'hFFFF, 2'b01, 2'd0, 13'h0048, 13'h0745, 2'b10);
    do_read (25'h0012345, 2'd0, 13'h0048, 13'h0745, 16'h3CFF);

    // Continuous read traffic across refresh expiries.
    last_ref  = -1;
    ref_at    = -1;
    nref      = 0;
    nvalid    = 0;
    ready_bad = 1'b0;
    data_bad  = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 25'h0012345;
    for (int k = 0; k < 1700; k++) begin
      tick();
      if (rdata_valid) begin
        nvalid++;
        if (rdata !== 16'h3CFF) data_bad = 1'b1;
      end
      if (cmd == C_REF) begin
        if (req_ready) ready_bad = 1'b1;
        if (last_ref >= 0)
          chk("refresh_gap_bound", 32'((k - last_ref) <= REFRESH_INTERVAL + 8), 32'h1);
        last_ref = k;
        ref_at   = k;
        nref++;
      end else if (ref_at >= 0) begin
        if ((k - ref_at) <= T_RFC && req_ready) ready_bad = 1'b1;
        if ((k - ref_at) == T_RFC + 1) chk("refresh_ready_return", 32'(req_ready), 32'h1);
        if ((k - ref_at) == T_RFC + 2) chk("refresh_then_act", 32'(cmd), 32'(C_ACT));
      end
    end
    req_valid = 1'b0;
    chk("refresh_count", 32'(nref >= 2), 32'h1);
    chk("refresh_ready_low", 32'(ready_bad), 32'h0);
    chk("stream_read_data", 32'(data_bad), 32'h0);
    chk("stream_reads_seen", 32'(nvalid > 100), 32'h1);

    // Asynchronous reset in the middle of a read.
    start_req(1'b0, 25'h1ABCDEF, 16'h0000, 2'b00);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_reset_values("midread_reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midread_no_valid", 32'(rdata_valid), 32'h0);
    end
    reset_n = 1'b1;
    check_init();
    do_read(25'h1ABCDEF, 2'd3, 13'h0AF3, 13'h05EF, 16'hA5C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
